// File: rtl/seq_pkg.sv
`default_nettype none
// ==========================================================================
// seq_pkg : encodings shared by the serializer and the pattern detectors
// Revision: 1.0
// ==========================================================================
package seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic MSB_FIRST = 1'b1;
  localparam logic LSB_FIRST = 1'b0;

endpackage
`default_nettype wire

// File: rtl/seq_piso_serializer.sv
`default_nettype none
// ==========================================================================
// seq_piso_serializer : valid/ready word input, one serial bit per clock
// Revision: 1.0
// ==========================================================================
module seq_piso_serializer #(
  parameter int   WIDTH     = 8,
  parameter logic MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_done,
  output logic             busy
);
  import seq_pkg::*;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [CW-1:0]    cnt;
  logic             accept;

  // The bit currently on x always sits at the head end of sr.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign accept = din_valid & din_ready;
  assign busy   = x_valid | hold_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sr         <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      cnt        <= '0;
      din_ready  <= 1'b0;
      x          <= IDLE_BIT;
      x_valid    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      din_ready <= !hold_full;
      case (state)
        ST_IDLE: begin
          x          <= IDLE_BIT;
          x_valid    <= 1'b0;
          frame_done <= 1'b0;
          if (accept) begin
            state   <= ST_SHIFT;
            sr      <= din;
            cnt     <= CNT_LAST;
            x       <= head_bit(din);
            x_valid <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (cnt != '0) begin
            sr         <= advance(sr);
            x          <= head_bit(advance(sr));
            cnt        <= cnt - CNT_ONE;
            frame_done <= (cnt == CNT_ONE);
            if (accept) begin
              hold      <= din;
              hold_full <= 1'b1;
              din_ready <= 1'b0;
            end
          end else begin
            frame_done <= 1'b0;
            if (hold_full) begin
              sr        <= hold;
              x         <= head_bit(hold);
              cnt       <= CNT_LAST;
              hold_full <= 1'b0;
              din_ready <= 1'b1;
            end else if (accept) begin
              // hold is empty, so a word arriving on the last bit goes straight to sr
              sr  <= din;
              x   <= head_bit(din);
              cnt <= CNT_LAST;
            end else begin
              state   <= ST_IDLE;
              x       <= IDLE_BIT;
              x_valid <= 1'b0;
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          x       <= IDLE_BIT;
          x_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_piso_serializer.sv
`default_nettype none
// ==========================================================================
// tb_seq_piso_serializer : MSB-first and LSB-first instances against a bit-queue model
// Revision: 1.0
// ==========================================================================
module tb_seq_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;

  logic rdy_m, x_m, xv_m, fd_m, busy_m;
  logic rdy_l, x_l, xv_l, fd_l, busy_l;

  always #5 clk = ~clk;

  seq_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .x(x_m), .x_valid(xv_m), .frame_done(fd_m), .busy(busy_m)
  );

  seq_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .x(x_l), .x_valid(xv_l), .frame_done(fd_l), .busy(busy_l)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: queue of serial bits still to appear, head = bit on x now.
  bit          qm[$];
  bit          ql[$];
  bit          exp_rdy = 1'b0;
  bit          acc = 1'b0;
  logic [31:0] cap_m, cap_l;
  int          cap_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      qm.push_back(w[W-1-i]);
      ql.push_back(w[i]);
    end
  endtask

  task automatic check_outputs();
    chk("m_x",      x_m,    (qm.size() > 0) ? qm[0] : 1'b0);
    chk("m_xvalid", xv_m,   qm.size() > 0);
    chk("m_fdone",  fd_m,   (qm.size() % W) == 1);
    chk("m_busy",   busy_m, qm.size() > 0);
    chk("m_ready",  rdy_m,  exp_rdy);
    chk("l_x",      x_l,    (ql.size() > 0) ? ql[0] : 1'b0);
    chk("l_xvalid", xv_l,   ql.size() > 0);
    chk("l_fdone",  fd_l,   (ql.size() % W) == 1);
    chk("l_busy",   busy_l, ql.size() > 0);
    chk("l_ready",  rdy_l,  exp_rdy);
  endtask

  task automatic cycle();
    @(posedge clk);
    acc = reset_n && din_valid && exp_rdy;
    if (reset_n) begin
      if (qm.size() > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (acc) push_word(din);
      // more than one word queued means the holding register is occupied
      exp_rdy = (qm.size() <= W);
    end
    #1;
    if (xv_m) begin
      cap_m = {cap_m[30:0], x_m};
      cap_l = {cap_l[30:0], x_l};
      cap_n++;
    end
    check_outputs();
  endtask

  task automatic cap_clear();
    cap_m = '0;
    cap_l = '0;
    cap_n = 0;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    qm.delete();
    ql.delete();
    exp_rdy = 1'b0;
    #1;
    check_outputs();
    repeat (n) cycle();
    reset_n = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] w);
    din       = w;
    din_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      cycle();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    cap_clear();
    #2;

    // reset held with din_valid high: nothing may be accepted
    din       = 8'hAA;
    din_valid = 1'b1;
    do_reset(3);
    chk("rst_ready_low", rdy_m, 1'b0);
    cycle();
    din_valid = 1'b0;
    chk("rel_ready", rdy_m, 1'b1);
    idle(2);

    // single word, MSB first
    cap_clear();
    send(8'hCC);
    idle(10);
    chk("cc_bits", cap_m[7:0], 8'hCC);
    chk("cc_len",  cap_n, 8);

    // LSB first on the second instance
    cap_clear();
    send(8'h01);
    idle(10);
    chk("lsb_bits", cap_l[7:0], 8'h80);
    chk("lsb_len",  cap_n, 8);

    // back-to-back with din_valid held high
    cap_clear();
    send(8'hA5);
    send(8'h3C);
    idle(20);
    chk("b2b_bits", cap_m[15:0], 16'hA53C);
    chk("b2b_len",  cap_n, 16);

    // reset after three bits of FF with 0F held
    send(8'hFF);
    send(8'h0F);
    cycle();
    do_reset(2);
    chk("midrst_x",    x_m,    1'b0);
    chk("midrst_busy", busy_m, 1'b0);
    cycle();
    cap_clear();
    send(8'h81);
    idle(10);
    chk("post_rst_bits", cap_m[7:0], 8'h81);
    chk("post_rst_len",  cap_n, 8);

    // word offered exactly on the last-bit cycle
    cap_clear();
    send(8'h5A);
    for (int t = 0; t < 20 && qm.size() != 1; t++) cycle();
    chk("bnd_fdone", fd_m, 1'b1);
    din       = 8'hC3;
    din_valid = 1'b1;
    cycle();
    chk("bnd_accept", acc, 1'b1);
    chk("bnd_ready",  rdy_m, 1'b1);
    din_valid = 1'b0;
    idle(20);
    chk("bnd_bits", cap_m[15:0], 16'h5AC3);
    chk("bnd_len",  cap_n, 16);

    // randomized producer that holds each word until accepted
    for (int c = 0; c < 600; c++) begin
      if (!din_valid && $urandom_range(0, 3) != 0) begin
        din       = W'($urandom);
        din_valid = 1'b1;
      end
      cycle();
      if (acc) din_valid = 1'b0;
    end
    din_valid = 1'b0;
    idle(24);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_piso_serializer.md
# seq_piso_serializer

Parallel-in/serial-out front end for the serial pattern detectors such as the 110011 Moore detector. It accepts WIDTH-bit words over a valid/ready handshake and drives one bit per clock on `x`, the single-bit serial input of the detector. A one-word holding register lets back-to-back words stream with no idle gap. When no word is in flight, the block drives a fixed idle level.

## Interface
- `WIDTH`, 8: word width; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 sends `din[WIDTH-1]` first; 0 sends `din[0]` first.
- `IDLE_BIT`, 0: level driven on `x` when no word is in flight.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `din`  in  WIDTH  parallel word; sampled on accept.
- `din_valid`  in  1  producer has a word on `din`.
- `din_ready`  out  1  block can take a word this cycle.
- `x`  out  1  serial bit to the detector; registered.
- `x_valid`  out  1  `x` carries a payload bit (not idle fill).
- `frame_done`  out  1  one-cycle pulse while the last bit of a word is on `x`.
- `busy`  out  1  word in flight or held; equals `x_valid | hold_full`.

## Operation
- **Accept rule:** a word is accepted on a rising edge where `din_valid & din_ready` is true.
- **Handshake:**
  - `din_ready = !hold_full`, driven from a register only.
  - A producer holds `din` and `din_valid` stable until the word is accepted.
- **Internal state:**
  - shift register `sr` [WIDTH].
  - down-counter `cnt` [$clog2(WIDTH)].
  - holding register `hold` [WIDTH] with flag `hold_full`.
  - FSM with states IDLE and SHIFT.
- **IDLE:**
  - `x = IDLE_BIT`, `x_valid = 0`, `hold_full = 0`.
  - On accept: load `sr` from `din` (bypassing `hold`), set `cnt = WIDTH-1`, go to SHIFT.
  - The first bit appears on `x` on the same edge.
- **SHIFT:**
  - Each edge presents the next bit, in the order set by `MSB_FIRST`, and decrements `cnt`.
  - While `cnt != 0`, an accept writes `hold` and sets `hold_full`.
- **Last bit (`cnt == 0`):** `frame_done = 1`. At the next edge, take the first matching case:
  1. `hold_full`: load `sr` from `hold`, clear `hold_full`, set `cnt = WIDTH-1`, stay in SHIFT.
  2. Accept this edge (`hold` empty): load `sr` from `din`, stay in SHIFT.
  3. Otherwise: go to IDLE; `x` returns to `IDLE_BIT` on that edge.
- **Holding-register conflict:** `hold_full` and an accept never coincide, because `din_ready` is low whenever `hold_full` is set.
- **Reset (asserted at any time, including mid-word):**
  - State → IDLE; `sr`, `hold`, `cnt` → 0; `hold_full` → 0.
  - Outputs: `x = IDLE_BIT`, `x_valid = 0`, `frame_done = 0`, `busy = 0`.
  - `din_ready` is forced to 0 while `reset_n` is low, then goes to 1 in the first cycle after release.
  - Partial words are discarded; there is no resume.
- **Downstream coupling:** the detector samples `x` every cycle and has no valid input. Idle fill therefore reaches it as real bits, and integrators choose `IDLE_BIT` accordingly.

## Timing
- **Latency:** accept at edge N → first bit on `x` from edge N to edge N+1. Bit k is valid from edge N+k to edge N+k+1.
- **Word rate:** one word per WIDTH cycles; fully gapless when the producer keeps `din_valid` high.
- **`din_ready` pattern under continuous `din_valid`:**
  - high in the first cycle;
  - high again in the cycle after the first bit;
  - low from the second accept until `hold` transfers at the word boundary;
  - sustained throughput of exactly WIDTH cycles per word.
- **Glitch-free outputs:** `x`, `x_valid`, `frame_done` and `busy` are functions of registers only, with no combinational path from `din` or `din_valid`.

## Structure
- **Shared package `seq_pkg`:** FSM encodings `ST_IDLE = 1'b0` and `ST_SHIFT = 1'b1`, plus the common bit-order constants `MSB_FIRST` / `LSB_FIRST`. The detector family reuses these.
- **Sub-modules:** none. The FSM, shifter and holding register form a single module of roughly 150–200 lines.

## Test plan
- **Reset:** hold `reset_n = 0` for 3 cycles while driving `din_valid = 1`.
  - During reset: `x = 0`, `x_valid = 0`, `din_ready = 0`, `busy = 0`, and no accept.
  - After release: `din_ready = 1`.
- **Single word:** `WIDTH = 8`, `MSB_FIRST = 1`, send `din = 8'hCC` once.
  - `x` = 1,1,0,0,1,1,0,0 over 8 cycles after accept; `x_valid` high for exactly 8 cycles.
  - `frame_done` pulses on the 8th bit; `x` returns to 0 afterwards.
  - With the 110011 detector attached, its `z` goes high one cycle after the 6th bit.
- **Back-to-back:** send `8'hA5` then `8'h3C` with `din_valid` held high.
  - 16 contiguous bits with no idle cycle; `din_ready` low during the second word's hold period.
  - `frame_done` pulses at bits 8 and 16.
- **LSB-first:** `MSB_FIRST = 0`, `din = 8'h01` → `x` = 1,0,0,0,0,0,0,0.
- **Reset mid-word:** assert `reset_n` low after 3 bits of `8'hFF`, with `hold` filled by `8'h0F`.
  - Immediately: `x = 0`, `x_valid = 0`, `busy = 0`.
  - After release: the next accepted `8'h81` serializes cleanly, with no remnant bits.
- **Boundary accept:** `hold` empty, `din_valid` rises exactly on the last-bit cycle (`frame_done = 1`).
  - The word loads directly into `sr`; serial output continues with no gap and `hold_full` stays 0.
